alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares a single `alu` instance (32-bit a/b, 4-bit sel, 32-bit c, combinational) between two requesters using valid/ready handshakes.
- Captures the winning request's operands, drives the ALU from registered operands, registers the result, and holds it until the owning requester accepts it.
- Sits between the ALU datapath and its two issuing units (e.g. two decode/issue ports).

Parameters:
- WIDTH, 32, operand/result width; must match the alu instance.
- SELW, 4, opcode width; must match the alu instance.
- CNTW, 16, width of the completed-operation counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a  in  WIDTH  operand a, requester 0
- req0_b  in  WIDTH  operand b, requester 0
- req0_sel  in  SELW  opcode, requester 0
- req1_valid / req1_ready / req1_a / req1_b / req1_sel  same as above, for requester 1
- rsp0_valid  out  1  result for requester 0 available
- rsp0_ready  in  1  requester 0 takes the result
- rsp1_valid  out  1  result for requester 1 available
- rsp1_ready  in  1  requester 1 takes the result
- rsp_c  out  WIDTH  registered ALU result; valid only while rsp0_valid or rsp1_valid is high
- busy  out  1  high in EXEC or RESP
- ops_count  out  CNTW  completed responses, wraps modulo 2^CNTW

Behaviour:
- Reset (async, rst=1): state=IDLE; rsp0_valid=0, rsp1_valid=0, rsp_c=0, busy=0, ops_count=0; operand regs=0; owner=0; last_grant=1. An in-flight operation is dropped: no response is issued and the count is not incremented.
- State IDLE:
  - reqN_ready = winner==N && reqN_valid (combinational; only in IDLE).
  - On the handshake edge: latch a, b, sel and owner=N; last_grant=N; go to EXEC.
  - No valid request: stay in IDLE.
- State EXEC:
  - Registered operands drive the alu.
  - At the edge: rsp_c<=alu c; rsp<owner>_valid<=1; go to RESP.
- State RESP:
  - rsp<owner>_valid stays high; rsp_c is stable.
  - On the edge where rsp<owner>_ready=1: rsp_valid<=0, ops_count<=ops_count+1, go to IDLE.
  - rsp<other>_ready is ignored.
- Latency:
  - Handshake at edge N gives rsp valid after edge N+1.
  - Earliest next accept is in the cycle after the response handshake.
  - Peak throughput is 1 operation per 3 cycles.
- Arbitration without the macro: fixed priority, requester 0 wins when both are valid.
- A requester's valid may drop before ready without side effects; operands are sampled only at the handshake edge.
- Requester inputs arriving while busy=1 are held off (ready=0); no queuing.
- The arbiter does not check or alter sel; all 16 codes pass through unchanged.
- ops_count wraps from 2^CNTW-1 to 0 with no flag.
- Never: both reqN_ready high, or both rspN_valid high.

Optional Feature:
- ALU_ARB_RR_EN
- Defined: round-robin arbitration. When both requesters are valid in IDLE, the winner is the one not equal to last_grant. Since last_grant resets to 1, requester 0 wins the first contended grant. A sole valid requester always wins.
- Undefined: fixed priority, requester 0 first; last_grant is still maintained but unused.

Test Plan:
- Basic operation, repeated for sel=0000..1111:
  - Stimulus: reset, then req0_valid=1, a=32'h1, b=32'h4, sel=4'b0000; rsp0_ready=1.
  - Response: req0_ready=1 in the first IDLE cycle; rsp0_valid=1 two cycles later; rsp_c equals a reference alu instance's c for (1,4,sel); ops_count increments by 1 per operation.
- Contention:
  - Stimulus: both requesters valid continuously (req0 a=1, b=4; req1 a=32'hFFFFFFFF, b=1); both rsp_ready=1.
  - Response without ALU_ARB_RR_EN: only requester 0 is granted.
  - Response with ALU_ARB_RR_EN: grants alternate 0,1,0,1 starting with 0.
- Response backpressure:
  - Stimulus: hold rsp0_ready=0 for 10 cycles while req1_valid=1.
  - Response: rsp0_valid and rsp_c stay stable; req1_ready=0 throughout; req1 is granted in the IDLE cycle after rsp0_ready rises.
- Reset mid-operation:
  - Stimulus: assert rst asynchronously in EXEC.
  - Response: immediately busy=0, rsp valids=0, rsp_c=0; ops_count=0; no response emitted after release.
- Counter wrap:
  - Stimulus: CNTW=2, complete 5 operations.
  - Response: ops_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two valid/ready requesters; define ALU_ARB_RR_EN for round-robin grants (default: requester 0 has fixed priority)
module alu #(
  parameter int WIDTH = 32,
  parameter int SELW  = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SELW-1:0]  sel,
  output logic [WIDTH-1:0] c
);
  localparam int SHW = $clog2(WIDTH);
  logic [SHW-1:0] w_sh;
  assign w_sh = b[SHW-1:0];
  always_comb begin
    c = '0;
    case (sel)
      4'd0:  c = a + b;
      4'd1:  c = a - b;
      4'd2:  c = a & b;
      4'd3:  c = a | b;
      4'd4:  c = a ^ b;
      4'd5:  c = ~(a | b);
      4'd6:  c = a << w_sh;
      4'd7:  c = a >> w_sh;
      4'd8:  c = $signed(a) >>> w_sh;
      4'd9:  c = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      4'd10: c = {{(WIDTH-1){1'b0}}, a < b};
      4'd11: c = a;
      4'd12: c = b;
      4'd13: c = ~a;
      4'd14: c = a + WIDTH'(1);
      default: c = ~(a & b);
    endcase
  end
endmodule

module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int SELW  = 4,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [SELW-1:0]  req0_sel,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [SELW-1:0]  req1_sel,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_c,
  output logic             busy,
  output logic [CNTW-1:0]  ops_count
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t            r_state, w_next;
  logic [WIDTH-1:0]  r_a, r_b, r_c, w_c;
  logic [SELW-1:0]   r_sel;
  logic              r_owner, r_last, r_rsp0, r_rsp1;
  logic [CNTW-1:0]   r_cnt;
  logic              w_idle, w_win, w_acc, w_ack;
  assign w_idle = r_state == IDLE;
`ifdef ALU_ARB_RR_EN
  assign w_win = req1_valid && (!req0_valid || !r_last);
`else
  // last grant is tracked in both builds; fixed priority masks it out
  assign w_win = req1_valid && !req0_valid && !(r_last & 1'b0);
`endif
  assign req0_ready = w_idle && !w_win && req0_valid;
  assign req1_ready = w_idle && w_win && req1_valid;
  assign w_acc      = req0_ready || req1_ready;
  assign w_ack      = r_owner ? rsp1_ready : rsp0_ready;
  assign rsp0_valid = r_rsp0;
  assign rsp1_valid = r_rsp1;
  assign rsp_c      = r_c;
  assign busy       = !w_idle;
  assign ops_count  = r_cnt;
  alu #(.WIDTH(WIDTH), .SELW(SELW)) u_alu (.a(r_a), .b(r_b), .sel(r_sel), .c(w_c));
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_acc ? EXEC : IDLE;
      EXEC:    w_next = RESP;
      RESP:    w_next = w_ack ? IDLE : RESP;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sel   <= '0;
      r_c     <= '0;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_rsp0  <= 1'b0;
      r_rsp1  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_a     <= w_win ? req1_a : req0_a;
        r_b     <= w_win ? req1_b : req0_b;
        r_sel   <= w_win ? req1_sel : req0_sel;
        r_owner <= w_win;
        r_last  <= w_win;
      end
      if (r_state == EXEC) begin
        r_c    <= w_c;
        r_rsp0 <= !r_owner;
        r_rsp1 <= r_owner;
      end
      if (r_state == RESP && w_ack) begin
        r_rsp0 <= 1'b0;
        r_rsp1 <= 1'b0;
        r_cnt  <= r_cnt + CNTW'(1);
      end
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter
module tb_alu_arbiter;
  logic        clk = 1'b0, rst = 1'b1;
  logic        req0_valid = 0, req1_valid = 0, rsp0_ready = 0, rsp1_ready = 0;
  logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic [3:0]  req0_sel = 0, req1_sel = 0;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
  logic [31:0] rsp_c;
  logic [15:0] ops_count;
  logic        w_r0, w_r1, w_v0, w_v1, w_busy2;
  logic [31:0] w_c2;
  logic [1:0]  ops2;
  int          n_tests = 0, n_fail = 0, cnt = 0;
  logic [31:0] exp_c [16] = '{32'h5, 32'hFFFFFFFD, 32'h0, 32'h5, 32'h5, 32'hFFFFFFFA, 32'h10, 32'h0,
                              32'h0, 32'h1, 32'h1, 32'h1, 32'h4, 32'hFFFFFFFE, 32'h2, 32'hFFFFFFFF};
  always #5 clk = ~clk;
  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_c(rsp_c), .busy(busy), .ops_count(ops_count)
  );
  alu_arbiter #(.CNTW(2)) dut2 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(w_r0), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(w_r1), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .rsp0_valid(w_v0), .rsp0_ready(rsp0_ready), .rsp1_valid(w_v1), .rsp1_ready(rsp1_ready),
    .rsp_c(w_c2), .busy(w_busy2), .ops_count(ops2)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic check_cnt();
    check("ops_count", 32'(ops_count), 32'(cnt));
    check("ops_wrap", 32'(ops2), 32'(cnt % 4));
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_v0", 32'(rsp0_valid), 0);
    check("rst_v1", 32'(rsp1_valid), 0);
    check("rst_c", rsp_c, 0);
    check_cnt();
    rst = 1'b0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    for (int s = 0; s < 16; s++) begin
      @(negedge clk);
      req0_valid = 1'b1; req0_a = 32'h1; req0_b = 32'h4; req0_sel = 4'(s);
      #1 check("basic_rdy0", 32'(req0_ready), 1);
      check("basic_rdy1", 32'(req1_ready), 0);
      @(negedge clk);
      req0_valid = 1'b0;
      check("basic_exec_busy", 32'(busy), 1);
      check("basic_exec_v0", 32'(rsp0_valid), 0);
      @(negedge clk);
      check("basic_v0", 32'(rsp0_valid), 1);
      check("basic_v1", 32'(rsp1_valid), 0);
      check($sformatf("basic_c_sel%0d", s), rsp_c, exp_c[s]);
      @(negedge clk);
      cnt++;
      check("basic_done_v0", 32'(rsp0_valid), 0);
      check_cnt();
    end
    @(negedge clk);
    req0_valid = 1'b1; req0_sel = 4'd0;
    @(negedge clk);
    req0_valid = 1'b0;
    check("mid_busy_pre", 32'(busy), 1);
    #2 rst = 1'b1;
    #1 check("mid_busy", 32'(busy), 0);
    check("mid_v0", 32'(rsp0_valid), 0);
    check("mid_c", rsp_c, 0);
    cnt = 0;
    check_cnt();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("mid_after_v0", 32'(rsp0_valid), 0);
      check("mid_after_busy", 32'(busy), 0);
      check_cnt();
    end
    req0_valid = 1'b1; req0_a = 32'h1; req0_b = 32'h4; req0_sel = 4'd0;
    req1_valid = 1'b1; req1_a = 32'hFFFFFFFF; req1_b = 32'h1; req1_sel = 4'd0;
    for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_RR_EN
      automatic int g = i % 2;
`else
      automatic int g = 0;
`endif
      #1 check("cont_rdy0", 32'(req0_ready), 32'(g == 0));
      check("cont_rdy1", 32'(req1_ready), 32'(g == 1));
      @(negedge clk);
      @(negedge clk);
      check("cont_v0", 32'(rsp0_valid), 32'(g == 0));
      check("cont_v1", 32'(rsp1_valid), 32'(g == 1));
      check("cont_c", rsp_c, g == 1 ? 32'h0 : 32'h5);
      @(negedge clk);
      cnt++;
      check_cnt();
    end
    rsp0_ready = 1'b0;
    #1 check("bp_rdy0", 32'(req0_ready), 1);
    check("bp_rdy1_idle", 32'(req1_ready), 0);
    @(negedge clk);
    req0_valid = 1'b0;
    check("bp_exec_rdy1", 32'(req1_ready), 0);
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      #1 check("bp_v0", 32'(rsp0_valid), 1);
      check("bp_c", rsp_c, 32'h5);
      check("bp_rdy1", 32'(req1_ready), 0);
      check("bp_v1", 32'(rsp1_valid), 0);
      @(negedge clk);
    end
    rsp0_ready = 1'b1;
    @(negedge clk);
    cnt++;
    #1 check("bp_grant1", 32'(req1_ready), 1);
    check("bp_v0_done", 32'(rsp0_valid), 0);
    check_cnt();
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    check("bp_rsp1_v1", 32'(rsp1_valid), 1);
    check("bp_rsp1_v0", 32'(rsp0_valid), 0);
    check("bp_rsp1_c", rsp_c, 32'h0);
    @(negedge clk);
    cnt++;
    check("bp_rsp1_done", 32'(rsp1_valid), 0);
    check_cnt();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
